// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {CS_n,RAS_n,CAS_n,WE_n},
// init-sequencer state encoding and the default mode register value.
package sdram_pkg;

    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

    // CAS latency 3, burst length 1, sequential burst.
    localparam logic [12:0] MODE_REG_DEFAULT = 13'h0030;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE      = 3'd1,
        PRE_WAIT = 3'd2,
        REF      = 3'd3,
        REF_WAIT = 3'd4,
        MRS      = 3'd5,
        MRS_WAIT = 3'd6,
        DONE     = 3'd7
    } state_t;

endpackage

// File: rtl/sdram_wait_tmr.sv
// Wait down-counter: iStart loads iLoad, the counter then decrements to zero.
// oExpire is high for the single cycle in which the count reads 1.
module sdram_wait_tmr #(
    parameter int W = 4
) (
    input  logic         iClk100,
    input  logic         iRst_n,
    input  logic         iStart,
    input  logic [W-1:0] iLoad,
    output logic         oExpire
);

    logic [W-1:0] cnt;

    always_ff @(posedge iClk100 or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt <= '0;
        end else if (iStart) begin
            cnt <= iLoad;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign oExpire = (cnt == W'(1));

endmodule

// File: rtl/sdram_init.sv
// SDRAM power-up sequencer: PRECHARGE ALL, REF_CNT x AUTO REFRESH, LOAD MODE,
// then a sticky oReady. Define SDRAM_INIT_STATE_OUT_EN to expose oState.
module sdram_init
    import sdram_pkg::*;
#(
    parameter int          T_RP     = 2,
    parameter int          T_RFC    = 7,
    parameter int          REF_CNT  = 8,
    parameter int          T_MRD    = 2,
    parameter logic [12:0] MODE_REG = MODE_REG_DEFAULT
) (
    input  logic        iClk100,
    input  logic        iRst_n,
    input  logic        iPorDone,
    output logic [3:0]  oCmd,
    output logic [12:0] oAddr,
    output logic [1:0]  oBa,
    output logic        oCke,
    output logic        oReady
`ifdef SDRAM_INIT_STATE_OUT_EN
    ,
    output logic [2:0]  oState
`endif
);

    localparam int T_MAX  = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                           : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
    localparam int WAIT_W = $clog2(T_MAX) + 1;

    state_t              state;
    logic [3:0]          refCnt;
    logic                tmrStart;
    logic [WAIT_W-1:0]   tmrLoad;
    logic                tmrExpire;

    // The timer loads on the command edge itself; expiry marks the last wait
    // edge, so gaps of T between commands need T_RP, T_RFC >= 2 and T_MRD >= 1.
    always_comb begin
        tmrStart = 1'b0;
        tmrLoad  = '0;
        case (state)
            PRE: begin
                tmrStart = 1'b1;
                tmrLoad  = WAIT_W'(T_RP - 1);
            end
            REF: begin
                tmrStart = 1'b1;
                tmrLoad  = WAIT_W'(T_RFC - 1);
            end
            MRS: begin
                tmrStart = 1'b1;
                tmrLoad  = WAIT_W'(T_MRD);
            end
            default: ;
        endcase
    end

    sdram_wait_tmr #(.W(WAIT_W)) uWaitTmr (
        .iClk100 (iClk100),
        .iRst_n  (iRst_n),
        .iStart  (tmrStart),
        .iLoad   (tmrLoad),
        .oExpire (tmrExpire)
    );

    always_ff @(posedge iClk100 or negedge iRst_n) begin
        if (!iRst_n) begin
            state  <= IDLE;
            oCmd   <= CMD_INHIBIT;
            oAddr  <= '0;
            oBa    <= '0;
            oCke   <= 1'b0;
            oReady <= 1'b0;
            refCnt <= '0;
        end else begin
            oAddr <= '0;
            oBa   <= '0;
            case (state)
                IDLE: begin
                    oCmd <= CMD_INHIBIT;
                    oCke <= 1'b0;
                    if (iPorDone) begin
                        oCmd  <= CMD_NOP;
                        oCke  <= 1'b1;
                        state <= PRE;
                    end
                end
                PRE: begin
                    oCmd      <= CMD_PRECHARGE;
                    oAddr[10] <= 1'b1;
                    refCnt    <= '0;
                    state     <= PRE_WAIT;
                end
                PRE_WAIT: begin
                    oCmd <= CMD_NOP;
                    if (tmrExpire) state <= REF;
                end
                REF: begin
                    oCmd   <= CMD_REFRESH;
                    refCnt <= refCnt + 4'd1;
                    state  <= REF_WAIT;
                end
                REF_WAIT: begin
                    oCmd <= CMD_NOP;
                    if (tmrExpire) state <= (refCnt == 4'(REF_CNT)) ? MRS : REF;
                end
                MRS: begin
                    oCmd  <= CMD_LOAD_MODE;
                    oAddr <= MODE_REG;
                    state <= MRS_WAIT;
                end
                MRS_WAIT: begin
                    oCmd <= CMD_NOP;
                    if (tmrExpire) begin
                        oReady <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    oCmd   <= CMD_NOP;
                    oCke   <= 1'b1;
                    oReady <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SDRAM_INIT_STATE_OUT_EN
    assign oState = state;
`endif

endmodule

// File: tb/tb_sdram_init.sv
// Bench for sdram_init: a default instance and a REF_CNT=1/T_RFC=3 instance
// share stimulus; a cycle-level timing model feeds a scoreboard queue.
module tb_sdram_init;
  import sdram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic por_done;

  logic [3:0]  cmd1, cmd2;
  logic [12:0] addr1, addr2;
  logic [1:0]  ba1, ba2;
  logic        cke1, cke2, rdy1, rdy2;
`ifdef SDRAM_INIT_STATE_OUT_EN
  logic [2:0]  st1, st2;
`endif

  sdram_init dut (
    .iClk100 (clk), .iRst_n (rst_n), .iPorDone (por_done),
    .oCmd (cmd1), .oAddr (addr1), .oBa (ba1), .oCke (cke1), .oReady (rdy1)
`ifdef SDRAM_INIT_STATE_OUT_EN
    , .oState (st1)
`endif
  );

  sdram_init #(.REF_CNT(1), .T_RFC(3)) dut2 (
    .iClk100 (clk), .iRst_n (rst_n), .iPorDone (por_done),
    .oCmd (cmd2), .oAddr (addr2), .oBa (ba2), .oCke (cke2), .oReady (rdy2)
`ifdef SDRAM_INIT_STATE_OUT_EN
    , .oState (st2)
`endif
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [18:0] exp_q[$];   // {cmd, addr, cke, ready} for dut
  logic [18:0] exp2_q[$];  // same for dut2
  bit started = 1'b0;
  int rel = 0;             // edges since the edge that first sampled iPorDone=1
  int n_pre[2], n_ref[2], n_lmr[2], rdy_rel[2];

  // Timing rules: edge k -> NOP/CKE, k+1 PRECHARGE, refresh n at k+1+tRp+n*tRfc,
  // LOAD MODE at k+1+tRp+nRef*tRfc, ready tMrd edges later and forever after.
  function automatic logic [18:0] model(bit st, int r, int tRp, int tRfc, int nRef, int tMrd);
    logic [3:0]  c;
    logic [12:0] a;
    logic        rd;
    int          lmr;
    if (!st) return {4'b1111, 13'd0, 1'b0, 1'b0};
    lmr = 1 + tRp + nRef * tRfc;
    c = 4'b0111;
    a = 13'd0;
    if (r == 1) begin
      c = 4'b0010;
      a = 13'h0400;
    end else if (r >= 1 + tRp && r < lmr && ((r - 1 - tRp) % tRfc) == 0) begin
      c = 4'b0001;
    end else if (r == lmr) begin
      c = 4'b0000;
      a = 13'h0030;
    end
    rd = (r >= lmr + tMrd);
    return {c, a, 1'b1, rd};
  endfunction

  task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_dut(int idx, logic [18:0] e, logic [3:0] c, logic [12:0] a,
                             logic [1:0] b, logic k, logic r);
    string tag;
    tag = (idx == 0) ? "dut" : "dut2";
    check({tag, "_cmd"},   32'(c), 32'(e[18:15]));
    check({tag, "_cke"},   32'(k), 32'(e[1]));
    check({tag, "_ready"}, 32'(r), 32'(e[0]));
    if (e[18:15] == 4'b0010) begin
      check({tag, "_pre_a10"}, 32'(a[10]), 1);
      check({tag, "_pre_ba"},  32'(b), 0);
    end
    if (e[18:15] == 4'b0000) begin
      check({tag, "_mrs_addr"}, 32'(a), 32'(e[14:2]));
      check({tag, "_mrs_ba"},   32'(b), 0);
    end
    if (c == 4'b0010) n_pre[idx]++;
    if (c == 4'b0001) n_ref[idx]++;
    if (c == 4'b0000) n_lmr[idx]++;
    if (started && r === 1'b1 && rdy_rel[idx] < 0) rdy_rel[idx] = rel;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    if (!rst_n) started = 1'b0;
    else if (started) rel++;
    else if (por_done) begin
      started = 1'b1;
      rel = 0;
    end
    exp_q.push_back(model(started, rel, 2, 7, 8, 2));
    exp2_q.push_back(model(started, rel, 2, 3, 1, 2));
    @(negedge clk);
    compare_dut(0, exp_q.pop_front(), cmd1, addr1, ba1, cke1, rdy1);
    compare_dut(1, exp2_q.pop_front(), cmd2, addr2, ba2, cke2, rdy2);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_pre[i] = 0; n_ref[i] = 0; n_lmr[i] = 0; rdy_rel[i] = -1;
    end
  endtask

  // Asserts reset and checks that outputs drop without waiting for a clock.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_cmd",   32'(cmd1),  32'(CMD_INHIBIT));
    check("rst_addr",  32'(addr1), 0);
    check("rst_ba",    32'(ba1),   0);
    check("rst_cke",   32'(cke1),  0);
    check("rst_ready", 32'(rdy1),  0);
    check("rst2_cmd",  32'(cmd2),  32'(CMD_INHIBIT));
    check("rst2_ready", 32'(rdy2), 0);
`ifdef SDRAM_INIT_STATE_OUT_EN
    check("rst_state", 32'(st1), 0);
`endif
    clear_counts();
  endtask

  typedef struct {
    int por_delay;
    bit raise;
    int drop_rel;
    int rst_rel;
    int exp_ref1;
    int exp_ref2;
    int exp_rdy1;
    int exp_rdy2;
  } scen_t;

  task automatic run_scen(scen_t s);
    bit rst_done;
    int budget;
    por_done = 1'b0;
    pulse_reset();
    step();
    rst_n = 1'b1;
    rst_done = (s.rst_rel < 0);
    for (int i = 0; i < s.por_delay; i++) step();
    if (s.raise) begin
      por_done = 1'b1;
      budget = 0;
      while (budget < 400 && !(rdy_rel[0] >= 0 && rdy_rel[1] >= 0 && rst_done)) begin
        step();
        budget++;
        if (started && rel == s.drop_rel) por_done = 1'b0;
        if (!rst_done && started && rel == s.rst_rel) begin
          pulse_reset();
          por_done = 1'b1;
          step();
          rst_n = 1'b1;
          rst_done = 1'b1;
        end
      end
      check("ready_within_budget", 32'(budget < 400), 1);
      // DONE must ignore iPorDone.
      for (int i = 0; i < 20; i++) begin
        por_done = 1'($urandom_range(0, 1));
        step();
      end
    end
    check("n_pre_dut",  n_pre[0], s.raise ? 1 : 0);
    check("n_ref_dut",  n_ref[0], s.exp_ref1);
    check("n_lmr_dut",  n_lmr[0], s.raise ? 1 : 0);
    check("rdy_rel_dut", rdy_rel[0], s.exp_rdy1);
    check("n_pre_dut2", n_pre[1], s.raise ? 1 : 0);
    check("n_ref_dut2", n_ref[1], s.exp_ref2);
    check("n_lmr_dut2", n_lmr[1], s.raise ? 1 : 0);
    check("rdy_rel_dut2", rdy_rel[1], s.exp_rdy2);
  endtask

  // ---------------- test sequence ----------------
  scen_t tbl[$];
  scen_t s;

  initial begin
    rst_n = 1'b0;
    por_done = 1'b0;
    clear_counts();
    repeat (2) @(negedge clk);

    // {por_delay, raise, drop_rel, rst_rel, ref1, ref2, ready_rel1, ready_rel2}
    s = '{10, 1'b1, -1, -1, 8, 1, 61, 8};   tbl.push_back(s);  // nominal
    s = '{3, 1'b1, 20, -1, 8, 1, 61, 8};    tbl.push_back(s);  // iPorDone drops at k+20
    s = '{0, 1'b1, -1, 34, 8, 1, 61, 8};    tbl.push_back(s);  // reset in 5th refresh wait
    s = '{1000, 1'b0, -1, -1, 0, 0, -1, -1}; tbl.push_back(s); // power-on never completes
    s = '{1, 1'b1, 1, 2, 8, 1, 61, 8};      tbl.push_back(s);  // drop right away, reset in PRE_WAIT

    for (int i = 0; i < 8; i++) begin
      s.por_delay = $urandom_range(0, 15);
      s.raise     = 1'b1;
      s.drop_rel  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 70)) : -1;
      s.rst_rel   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 60)) : -1;
      s.exp_ref1  = 8;
      s.exp_ref2  = 1;
      s.exp_rdy1  = 61;
      s.exp_rdy2  = 8;
      tbl.push_back(s);
    end

    foreach (tbl[i]) run_scen(tbl[i]);

    // Reset asserted in the middle of a cycle (not aligned to a clock edge).
    por_done = 1'b0;
    pulse_reset();
    step();
    rst_n = 1'b1;
    por_done = 1'b1;
    repeat (30) step();
    #2;
    pulse_reset();
    step();
    rst_n = 1'b1;
    repeat (70) step();
    check("midcycle_rst_rdy_rel", rdy_rel[0], 61);

    check("exp_q_drained", exp_q.size() + exp2_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
